tx_msg_sequencer: RTL and testbench
===================================

Name: tx_msg_sequencer

Overview:
- Byte source for the UART transmitter.
- Selects one of NUM_MSG stored null-terminated messages, or the switch byte, and feeds it byte-by-byte to the transmitter using the ready/enable handshake.
- Generalises the single-message selector: parametrised data width, message count and length, plus a runtime message select, abort, acknowledge timeout and status outputs.
- Sits between button_lockout outputs and UART_tx, under the Lab top level.

Parameters:
- DATA_W, 8, width of data_sw and data_out; ROM characters are zero-extended to DATA_W.
- NUM_MSG, 4, number of stored messages (power of two, min 2).
- MSG_LEN, 16, maximum bytes per message including terminator.
- ACK_TIMEOUT, 1024, cycles allowed for ready to fall after an enable pulse.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- button_0  in  1  one-cycle pulse: send data_sw once.
- button_1  in  1  one-cycle pulse: send message msg_sel.
- msg_sel  in  $clog2(NUM_MSG)  message index, sampled on button_1.
- data_sw  in  DATA_W  switch byte, sampled on button_0.
- abort  in  1  stop the current message after the in-flight byte.
- ready  in  1  transmitter idle/ready.
- data_out  out  DATA_W  byte to the transmitter, held stable while in flight.
- enable  out  1  one-cycle start strobe to the transmitter.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a send completes normally.
- err  out  1  one-cycle pulse on acknowledge timeout.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - data_out=0, enable=0, busy=0, done=0, err=0.
  - Index, timeout counter and latched select are cleared.
- ROM contents, fixed, one 0x00 terminator each:
  - msg0 "Hello Cari!"
  - msg1 "CST 231\r\n"
  - msg2 "OK\r\n"
  - msg3 "ERR\r\n"
  - Unused entries (NUM_MSG>4) hold a lone terminator.
  - Index MSG_LEN-1 is always treated as the terminator.
- State machine, all outputs registered:
  - IDLE:
    - button_0 takes priority over button_1 when both pulse in the same cycle.
    - button_0: latch data_sw, go SEND_SW.
    - button_1: latch msg_sel, idx=0, go FETCH.
    - Buttons are ignored in every state other than IDLE.
  - SEND_SW: wait ready=1, then data_out=latched byte, enable=1 for one cycle, go WAIT_ACK with single-byte flag set.
  - FETCH: read ROM[sel][idx].
    - Char is 0x00: go FINISH; a zero-length message sends no bytes and still pulses done.
    - Otherwise: go ISSUE.
  - ISSUE: wait ready=1, then data_out=char, enable=1 for exactly one cycle, clear the timeout counter, go WAIT_ACK.
  - WAIT_ACK:
    - ready=0: go WAIT_RDY.
    - Counter reaches ACK_TIMEOUT-1: pulse err, go IDLE, no done pulse.
  - WAIT_RDY: on ready=1:
    - Single-byte flag set, or abort latched: go FINISH.
    - Otherwise: idx+1, go FETCH.
  - FINISH: pulse done for one cycle, go IDLE.
- Latency:
  - Button pulse to first enable is 2 cycles when ready is already high (3 for a message, via FETCH).
  - Byte-to-byte spacing is set by the transmitter's ready timing.
- data_out holds its value from enable until the next enable; it returns to 0 only on reset.
- abort:
  - Sampled in any non-IDLE state and held latched until IDLE.
  - Never truncates a byte already strobed.
  - Abort still produces done; the truncated count is visible only on the wire.
- busy falls in the cycle after FINISH or the err pulse.
- Async reset mid-message returns to IDLE immediately; no done pulse.

Optional Feature:
- Macro REPEAT_EN.
- Defined:
  - Adds input port repeat (1 bit).
  - In FINISH, if repeat=1 and abort is not latched, pulse done, reset idx to 0 and go FETCH instead of IDLE, restarting the same message.
  - Deasserting repeat lets the current message finish, then the block returns to IDLE.
- Undefined: no repeat port; FINISH always goes to IDLE.

Test Plan:
- Switch byte: reset released, ready=1, data_sw=0x5A, pulse button_0 -> one enable with data_out=0x5A; drop ready 3 cycles, raise it -> done pulse, busy=0.
- Message: msg_sel=0, pulse button_1, transmitter model holds ready low 10 cycles per byte -> 11 enables carrying "Hello Cari!" in order, then one done; no enable for the terminator.
- Abort: send msg1, assert abort during the 3rd byte -> exactly 3 bytes "CST" sent, done pulses, busy low.
- Timeout: ACK_TIMEOUT=16, ready held high after the first enable -> err pulses 16 cycles after enable, no done, state IDLE, the next button_1 is accepted.
- Priority and reset: button_0 and button_1 in the same cycle -> only the switch byte is sent; assert reset mid-msg0 -> enable=0, busy=0, data_out=0 immediately.
- REPEAT_EN: repeat=1, msg2 -> "OK\r\n" repeats with a done pulse per pass; drop repeat -> one more full pass, then IDLE.

Source files
------------

// File: rtl/tx_msg_sequencer.sv
// tx_msg_sequencer: byte source for the UART transmitter.
// Sends either the switch byte (button_0) or one of NUM_MSG stored
// null-terminated messages (button_1, msg_sel) one byte at a time.
// Supports abort, an acknowledge timeout and busy/done/err status.
//
// Optional build feature: define REPEAT_EN to add the repeat_msg input.
// The port cannot be called "repeat" because that is a reserved word.
// When repeat_msg is high, a finished message restarts from its first byte
// instead of returning to IDLE.
//
// Transmitter handshake:
//   enable is a one-cycle strobe and is issued only while ready=1.
//   data_out becomes valid in the same cycle as enable. It then holds until
//   the next enable. The transmitter acknowledges by dropping ready. It
//   raises ready again once the byte is on the wire. If ready has not fallen
//   within ACK_TIMEOUT cycles of the strobe, err pulses and the send ends.
module tx_msg_sequencer #(
  parameter int DATA_W      = 8,
  parameter int NUM_MSG     = 4,
  parameter int MSG_LEN     = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       button_0,
  input  logic                       button_1,
  input  logic [$clog2(NUM_MSG)-1:0] msg_sel,
  input  logic [DATA_W-1:0]          data_sw,
  input  logic                       abort,
  input  logic                       ready,
`ifdef REPEAT_EN
  input  logic                       repeat_msg,
`endif
  output logic [DATA_W-1:0]          data_out,
  output logic                       enable,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [2:0]                 state_dbg
);

  localparam int SEL_W  = $clog2(NUM_MSG);
  localparam int IDX_W  = $clog2(MSG_LEN);
  localparam int TCNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(ACK_TIMEOUT - 1);

  // Message ROM text. Characters are stored MSB-first, as SV string literals are.
  localparam int LEN0 = 11;
  localparam int LEN1 = 9;
  localparam int LEN2 = 4;
  localparam int LEN3 = 5;
  localparam logic [8*LEN0-1:0] MSG0 = "Hello Cari!";
  localparam logic [8*LEN1-1:0] MSG1 = "CST 231\r\n";
  localparam logic [8*LEN2-1:0] MSG2 = "OK\r\n";
  localparam logic [8*LEN3-1:0] MSG3 = "ERR\r\n";

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_SW  = 3'd1,
    FETCH    = 3'd2,
    ISSUE    = 3'd3,
    WAIT_ACK = 3'd4,
    WAIT_RDY = 3'd5,
    FINISH   = 3'd6
  } state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel;        // message selected at button_1
  logic [IDX_W-1:0]   idx;        // current character index
  logic [TCNT_W-1:0]  tcnt;       // cycles spent waiting for ready to fall
  logic [DATA_W-1:0]  pend;       // byte waiting to be strobed
  logic               single;     // current send is the lone switch byte
  logic               abort_lat;  // abort seen since leaving IDLE
  logic [7:0]         rom_byte;

  // Look up one ROM character. The last index and anything past a message's
  // own text read as the terminator. Entries beyond msg3 are empty.
  function automatic logic [7:0] rom_char(input logic [SEL_W-1:0] s,
                                          input logic [IDX_W-1:0] i);
    int ii;
    int ss;
    ii = int'(i);
    ss = int'(s);
    rom_char = 8'h00;
    if (ii < MSG_LEN - 1) begin
      case (ss)
        0: if (ii < LEN0) rom_char = MSG0[8*(LEN0-1-ii) +: 8];
        1: if (ii < LEN1) rom_char = MSG1[8*(LEN1-1-ii) +: 8];
        2: if (ii < LEN2) rom_char = MSG2[8*(LEN2-1-ii) +: 8];
        3: if (ii < LEN3) rom_char = MSG3[8*(LEN3-1-ii) +: 8];
        default: rom_char = 8'h00;
      endcase
    end
  endfunction

  // Character addressed by the latched select and the current index.
  always_comb begin
    rom_byte = 8'h00;
    rom_byte = rom_char(sel, idx);
  end

  assign state_dbg = state;

  // Sequencer FSM. Every output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sel       <= '0;
      idx       <= '0;
      tcnt      <= '0;
      pend      <= '0;
      single    <= 1'b0;
      abort_lat <= 1'b0;
      data_out  <= '0;
      enable    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      enable <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;

      // Abort only stops the send at the next byte boundary, so it is
      // remembered until the sequencer returns to IDLE.
      if (state != IDLE && abort) abort_lat <= 1'b1;

      case (state)
        IDLE: begin
          abort_lat <= 1'b0;
          if (button_0) begin
            pend   <= data_sw;
            single <= 1'b1;
            state  <= SEND_SW;
            busy   <= 1'b1;
          end else if (button_1) begin
            sel    <= msg_sel;
            idx    <= '0;
            single <= 1'b0;
            state  <= FETCH;
            busy   <= 1'b1;
          end
        end

        SEND_SW: begin
          if (ready) begin
            data_out <= pend;
            enable   <= 1'b1;
            tcnt     <= '0;
            state    <= WAIT_ACK;
          end
        end

        FETCH: begin
          if (rom_byte == 8'h00) begin
            state <= FINISH;
          end else begin
            pend  <= DATA_W'(rom_byte);
            state <= ISSUE;
          end
        end

        ISSUE: begin
          if (ready) begin
            data_out <= pend;
            enable   <= 1'b1;
            tcnt     <= '0;
            state    <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (!ready) begin
            state <= WAIT_RDY;
          end else if (tcnt == TCNT_LAST) begin
            err       <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            abort_lat <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        WAIT_RDY: begin
          if (ready) begin
            if (single || abort_lat || abort) begin
              state <= FINISH;
            end else begin
              idx   <= idx + 1'b1;
              state <= FETCH;
            end
          end
        end

        FINISH: begin
          done      <= 1'b1;
          state     <= IDLE;
          busy      <= 1'b0;
          abort_lat <= 1'b0;
`ifdef REPEAT_EN
          if (repeat_msg && !single && !abort_lat && !abort) begin
            idx   <= '0;
            state <= FETCH;
            busy  <= 1'b1;
          end
`endif
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_msg_sequencer.sv
// Bench for tx_msg_sequencer: directed sends against a transmitter model.
// Expected bytes come from the message text, queued before each send.
module tb_tx_msg_sequencer;

  localparam int DATA_W = 8;

  // ---------------- clock / reset / signals ----------------
  logic              clk;
  logic              reset;
  logic              button_0 = 1'b0;
  logic              button_1 = 1'b0;
  logic [1:0]        msg_sel  = '0;
  logic [DATA_W-1:0] data_sw  = '0;
  logic              abort    = 1'b0;
  logic              ready;
`ifdef REPEAT_EN
  logic              repeat_msg = 1'b0;
`endif
  logic [DATA_W-1:0] data_out;
  logic              enable;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        state_dbg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  tx_msg_sequencer #(
    .DATA_W(DATA_W), .NUM_MSG(4), .MSG_LEN(16), .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .button_0(button_0), .button_1(button_1),
    .msg_sel(msg_sel), .data_sw(data_sw), .abort(abort), .ready(ready),
`ifdef REPEAT_EN
    .repeat_msg(repeat_msg),
`endif
    .data_out(data_out), .enable(enable), .busy(busy), .done(done),
    .err(err), .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int vec_cnt = 0;
  int mis_cnt = 0;
  int cyc = 0;
  int en_count = 0, done_count = 0, err_count = 0;
  int en_cyc = 0, err_cyc = 0, press_cyc = 0;
  int tx_hold = 3;
  bit tx_stuck = 1'b0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_byte = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transmitter model ----------------
  // Drops ready for tx_hold cycles after each strobe, unless tx_stuck.
  initial begin
    ready = 1'b1;
    forever begin
      @(negedge clk);
      if (enable && !tx_stuck) begin
        ready = 1'b0;
        repeat (tx_hold) @(negedge clk);
        ready = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / compare process ----------------
  initial begin
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (enable) begin
        en_count++;
        en_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("spurious_enable", enable, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", data_out, e);
          last_byte = e;
        end
      end else begin
        check("data_hold", data_out, last_byte);
      end
      if (done) begin
        done_count++;
        check("busy_low_at_done", busy, 1'b0);
      end
      if (err) begin
        err_count++;
        err_cyc = cyc;
        check("busy_low_at_err", busy, 1'b0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic int cnt_of(input int which);
    case (which)
      0: return en_count;
      1: return done_count;
      default: return err_count;
    endcase
  endfunction

  task automatic wait_count(input string name, input int which, input int target, input int limit);
    int n;
    n = 0;
    while (cnt_of(which) < target && n < limit) begin
      step(1);
      n++;
    end
    check(name, 32'(cnt_of(which) >= target), 32'd1);
  endtask

  task automatic push_msg(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(DATA_W'(s[i]));
  endtask

  task automatic press_b0(input logic [DATA_W-1:0] b);
    data_sw   = b;
    button_0  = 1'b1;
    press_cyc = cyc;
    step(1);
    button_0  = 1'b0;
  endtask

  task automatic press_b1(input int s);
    msg_sel   = 2'(s);
    button_1  = 1'b1;
    press_cyc = cyc;
    step(1);
    button_1  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int e0, d0, r0;
    reset = 1'b0;
    step(3);
    check("rst_data_out", data_out, 0);
    check("rst_enable", enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 1'b1;
    step(2);

    // Switch byte
    e0 = en_count; d0 = done_count; r0 = err_count;
    tx_hold = 3;
    exp_q.push_back(8'h5A);
    press_b0(8'h5A);
    wait_count("sw_done_wait", 1, d0 + 1, 100);
    check("sw_latency", en_cyc - press_cyc, 2);
    check("sw_enables", en_count - e0, 1);
    check("sw_data_out", data_out, 8'h5A);
    check("sw_busy", busy, 0);
    step(3);

    // Full message 0 with slow transmitter
    e0 = en_count; d0 = done_count;
    tx_hold = 10;
    push_msg("Hello Cari!");
    press_b1(0);
    wait_count("msg0_first_en", 0, e0 + 1, 20);
    check("msg0_latency", en_cyc - press_cyc, 3);
    wait_count("msg0_done_wait", 1, d0 + 1, 1000);
    check("msg0_enables", en_count - e0, 11);
    check("msg0_last_char", data_out, 8'h21);
    check("msg0_queue_empty", exp_q.size(), 0);
    check("msg0_busy", busy, 0);
    step(5);
    check("msg0_one_done", done_count - d0, 1);

    // Abort during 3rd byte of msg1
    e0 = en_count; d0 = done_count;
    push_msg("CST");
    press_b1(1);
    wait_count("abort_third_en", 0, e0 + 3, 500);
    abort = 1'b1;
    step(2);
    abort = 1'b0;
    wait_count("abort_done_wait", 1, d0 + 1, 200);
    step(20);
    check("abort_enables", en_count - e0, 3);
    check("abort_last_char", data_out, 8'h54);
    check("abort_busy", busy, 0);
    check("abort_one_done", done_count - d0, 1);

    // Acknowledge timeout: ready never falls
    e0 = en_count; d0 = done_count; r0 = err_count;
    tx_stuck = 1'b1;
    exp_q.push_back(8'h4F);
    press_b1(2);
    wait_count("to_err_wait", 2, r0 + 1, 100);
    check("to_err_delay", err_cyc - en_cyc, 16);
    check("to_no_done", done_count - d0, 0);
    check("to_busy", busy, 0);
    check("to_enables", en_count - e0, 1);
    tx_stuck = 1'b0;
    tx_hold = 2;
    e0 = en_count; d0 = done_count;
    push_msg("ERR\r\n");
    press_b1(3);
    wait_count("to_next_done", 1, d0 + 1, 300);
    check("to_next_enables", en_count - e0, 5);
    check("to_next_last", data_out, 8'h0A);
    step(3);

    // Both buttons in one cycle: switch byte wins
    e0 = en_count; d0 = done_count;
    tx_hold = 3;
    exp_q.push_back(8'hC3);
    msg_sel = 2'd0;
    data_sw = 8'hC3;
    button_0 = 1'b1;
    button_1 = 1'b1;
    step(1);
    button_0 = 1'b0;
    button_1 = 1'b0;
    wait_count("prio_done", 1, d0 + 1, 100);
    step(10);
    check("prio_enables", en_count - e0, 1);
    check("prio_data_out", data_out, 8'hC3);

    // Reset in the middle of msg0
    e0 = en_count; d0 = done_count;
    tx_hold = 10;
    push_msg("Hello Cari!");
    press_b1(0);
    wait_count("rst_mid_wait", 0, e0 + 2, 200);
    reset = 1'b0;
    #1;
    check("rst_mid_enable", enable, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_data_out", data_out, 0);
    exp_q.delete();
    last_byte = '0;
    step(3);
    reset = 1'b1;
    step(15);
    check("rst_mid_no_done", done_count - d0, 0);
    e0 = en_count; d0 = done_count;
    tx_hold = 3;
    exp_q.push_back(8'h81);
    press_b0(8'h81);
    wait_count("rst_recover_done", 1, d0 + 1, 100);
    check("rst_recover_en", en_count - e0, 1);
    check("rst_recover_data", data_out, 8'h81);

`ifdef REPEAT_EN
    // Repeat: three passes of "OK\r\n", repeat dropped during the third
    step(3);
    e0 = en_count; d0 = done_count;
    tx_hold = 2;
    push_msg("OK\r\n");
    push_msg("OK\r\n");
    push_msg("OK\r\n");
    repeat_msg = 1'b1;
    press_b1(2);
    wait_count("rep_two_passes", 1, d0 + 2, 300);
    check("rep_busy_between", busy, 1);
    repeat_msg = 1'b0;
    wait_count("rep_third_pass", 1, d0 + 3, 300);
    step(10);
    check("rep_enables", en_count - e0, 12);
    check("rep_dones", done_count - d0, 3);
    check("rep_busy_end", busy, 0);
`endif

    step(5);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
